// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared seven-segment definitions used by the decoder and the existing encoder.
// Patterns are 7 bits {A,B,C,D,E,F,G}, A as MSB, 1 = segment lit.
//   SEG_0 .. SEG_F : the sixteen hex digit patterns
//   SEG_BLANK      : all segments off
//   state_t        : decoder FSM states
// -----------------------------------------------------------------------------
package seg7_pkg;

   localparam logic [6:0] SEG_0     = 7'h7E;
   localparam logic [6:0] SEG_1     = 7'h30;
   localparam logic [6:0] SEG_2     = 7'h6D;
   localparam logic [6:0] SEG_3     = 7'h79;
   localparam logic [6:0] SEG_4     = 7'h33;
   localparam logic [6:0] SEG_5     = 7'h5B;
   localparam logic [6:0] SEG_6     = 7'h5F;
   localparam logic [6:0] SEG_7     = 7'h70;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h7B;
   localparam logic [6:0] SEG_A     = 7'h77;
   localparam logic [6:0] SEG_B     = 7'h1F;
   localparam logic [6:0] SEG_C     = 7'h4E;
   localparam logic [6:0] SEG_D     = 7'h3D;
   localparam logic [6:0] SEG_E     = 7'h4F;
   localparam logic [6:0] SEG_F     = 7'h47;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

endpackage

// File: rtl/segment_pattern_lookup.sv
// -----------------------------------------------------------------------------
// segment_pattern_lookup
// Purely combinational match of a 7-bit segment pattern against the sixteen
// hex digit patterns.
// Ports:
//   i_Pattern [6:0] : pattern {A..G}, 1 = lit
//   o_Hit           : 1 when the pattern is one of the sixteen digits
//   o_Digit   [3:0] : matched digit value (0 when o_Hit is low)
// Blank is not a hit; the caller distinguishes blank from illegal.
// -----------------------------------------------------------------------------
module segment_pattern_lookup
   import seg7_pkg::*;
(
   input  logic [6:0] i_Pattern,
   output logic       o_Hit,
   output logic [3:0] o_Digit
);

   always_comb begin
      o_Hit   = 1'b1;
      o_Digit = 4'h0;
      case (i_Pattern)
         SEG_0:   o_Digit = 4'h0;
         SEG_1:   o_Digit = 4'h1;
         SEG_2:   o_Digit = 4'h2;
         SEG_3:   o_Digit = 4'h3;
         SEG_4:   o_Digit = 4'h4;
         SEG_5:   o_Digit = 4'h5;
         SEG_6:   o_Digit = 4'h6;
         SEG_7:   o_Digit = 4'h7;
         SEG_8:   o_Digit = 4'h8;
         SEG_9:   o_Digit = 4'h9;
         SEG_A:   o_Digit = 4'hA;
         SEG_B:   o_Digit = 4'hB;
         SEG_C:   o_Digit = 4'hC;
         SEG_D:   o_Digit = 4'hD;
         SEG_E:   o_Digit = 4'hE;
         SEG_F:   o_Digit = 4'hF;
         default: o_Hit   = 1'b0;
      endcase
   end

endmodule

// File: rtl/seven_segment_to_binary.sv
// -----------------------------------------------------------------------------
// seven_segment_to_binary
// Decodes active-low seven-segment lines back into a hex digit, accepting a
// pattern only after it has been stable for STABLE_CYCLES registered samples.
// Parameter:
//   STABLE_CYCLES (1..255, default 4) : consecutive identical samples required
// Ports:
//   i_Clk, i_Reset (sync, active-high)
//   i_Segment_A..i_Segment_G : active-low segment lines
//   o_Binary_Num [3:0]       : last legally decoded digit
//   o_Valid                  : 1-cycle pulse on acceptance of a legal digit
//   o_Error                  : 1-cycle pulse on acceptance of an illegal pattern
//   o_Blank                  : level, high while the accepted pattern is blank
//   o_Dbg_State              : current FSM state, for observation only
//   o_Error_Count [7:0]      : saturating o_Error pulse count, present only
//                              when macro SEG_ERROR_COUNT_EN is defined
// Latency from a new input pattern to the output update is STABLE_CYCLES+2
// clocks: one to register, one to detect the change, STABLE_CYCLES-1 to count,
// one to register the outputs.
// -----------------------------------------------------------------------------
module seven_segment_to_binary
   import seg7_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 4
)(
   input  logic       i_Clk,
   input  logic       i_Reset,
   input  logic       i_Segment_A,
   input  logic       i_Segment_B,
   input  logic       i_Segment_C,
   input  logic       i_Segment_D,
   input  logic       i_Segment_E,
   input  logic       i_Segment_F,
   input  logic       i_Segment_G,
   output logic [3:0] o_Binary_Num,
   output logic       o_Valid,
   output logic       o_Error,
   output logic       o_Blank,
   output state_t     o_Dbg_State
`ifdef SEG_ERROR_COUNT_EN
   ,
   output logic [7:0] o_Error_Count
`endif
);

   localparam logic [7:0] LAST_COUNT = 8'(STABLE_CYCLES - 1);

   logic [6:0] r_Pattern;
   logic [6:0] r_Prev_Pattern;
   logic       r_Primed;
   state_t     r_State;
   logic [7:0] r_Count;
   logic [3:0] r_Binary_Num;
   logic       r_Valid;
   logic       r_Error;
   logic       r_Blank;

   state_t     w_Next_State;
   logic [7:0] w_Next_Count;
   logic       w_Accept;
   logic       w_Changed;
   logic       w_Hit;
   logic [3:0] w_Digit;
   logic       w_Is_Blank;

   segment_pattern_lookup u_lookup (
      .i_Pattern (r_Pattern),
      .o_Hit     (w_Hit),
      .o_Digit   (w_Digit)
   );

   assign w_Changed  = (r_Pattern != r_Prev_Pattern);
   assign w_Is_Blank = (r_Pattern == SEG_BLANK);

   // Input capture. r_Primed marks that r_Pattern holds a real sample rather
   // than its reset value, so IDLE knows when the first sample is available.
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r_Pattern      <= 7'h00;
         r_Prev_Pattern <= 7'h00;
         r_Primed       <= 1'b0;
      end else begin
         r_Pattern      <= ~{i_Segment_A, i_Segment_B, i_Segment_C, i_Segment_D,
                             i_Segment_E, i_Segment_F, i_Segment_G};
         r_Prev_Pattern <= r_Pattern;
         r_Primed       <= 1'b1;
      end
   end

   // FSM state and stability counter
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r_State <= ST_IDLE;
         r_Count <= 8'd0;
      end else begin
         r_State <= w_Next_State;
         r_Count <= w_Next_Count;
      end
   end

   always_comb begin
      w_Next_State = r_State;
      w_Next_Count = r_Count;
      w_Accept     = 1'b0;
      case (r_State)
         ST_IDLE: begin
            // The first real sample counts as a change, whatever its value.
            if (r_Primed) begin
               w_Next_State = ST_SETTLE;
               w_Next_Count = 8'd0;
            end
         end
         ST_SETTLE: begin
            if (w_Changed) begin
               w_Next_Count = 8'd0;
            end else if (r_Count >= LAST_COUNT) begin
               w_Accept     = 1'b1;
               w_Next_State = ST_LOCKED;
            end else begin
               // Only reached below LAST_COUNT, so the counter cannot wrap.
               w_Next_Count = r_Count + 8'd1;
            end
         end
         ST_LOCKED: begin
            if (w_Changed) begin
               w_Next_State = ST_SETTLE;
               w_Next_Count = 8'd0;
            end
         end
         default: begin
            w_Next_State = ST_IDLE;
            w_Next_Count = 8'd0;
         end
      endcase
   end

   // Output registers. Valid and error come from mutually exclusive branches.
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r_Binary_Num <= 4'h0;
         r_Valid      <= 1'b0;
         r_Error      <= 1'b0;
         r_Blank      <= 1'b0;
      end else begin
         r_Valid <= 1'b0;
         r_Error <= 1'b0;
         if (w_Accept) begin
            if (w_Is_Blank) begin
               r_Blank <= 1'b1;
            end else if (w_Hit) begin
               r_Binary_Num <= w_Digit;
               r_Valid      <= 1'b1;
               r_Blank      <= 1'b0;
            end else begin
               r_Error <= 1'b1;
               r_Blank <= 1'b0;
            end
         end
      end
   end

`ifdef SEG_ERROR_COUNT_EN
   logic [7:0] r_Error_Count;

   // Steps on the same edge that raises o_Error, saturating at 255.
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r_Error_Count <= 8'd0;
      end else if (w_Accept && !w_Is_Blank && !w_Hit && (r_Error_Count != 8'hFF)) begin
         r_Error_Count <= r_Error_Count + 8'd1;
      end
   end

   assign o_Error_Count = r_Error_Count;
`endif

   assign o_Binary_Num = r_Binary_Num;
   assign o_Valid      = r_Valid;
   assign o_Error      = r_Error;
   assign o_Blank      = r_Blank;
   assign o_Dbg_State  = r_State;

endmodule

// File: tb/tb_seven_segment_to_binary.sv
// -----------------------------------------------------------------------------
// tb_seven_segment_to_binary
// Directed test of the seven-segment decoder with STABLE_CYCLES = 4
// (expected acceptance 6 clocks after a new pattern is driven).
// Build with SEG_ERROR_COUNT_EN defined to also check o_Error_Count.
// -----------------------------------------------------------------------------
module tb_seven_segment_to_binary;
   import seg7_pkg::*;

   logic       i_Clk = 1'b0;
   logic       i_Reset = 1'b1;
   logic       i_Segment_A = 1'b1;
   logic       i_Segment_B = 1'b1;
   logic       i_Segment_C = 1'b1;
   logic       i_Segment_D = 1'b1;
   logic       i_Segment_E = 1'b1;
   logic       i_Segment_F = 1'b1;
   logic       i_Segment_G = 1'b1;
   logic [3:0] o_Binary_Num;
   logic       o_Valid;
   logic       o_Error;
   logic       o_Blank;
   state_t     o_Dbg_State;
`ifdef SEG_ERROR_COUNT_EN
   logic [7:0] o_Error_Count;
`endif

   int n_compared   = 0;
   int n_mismatched = 0;
   int n_both       = 0;

   seven_segment_to_binary #(.STABLE_CYCLES(4)) dut (
      .i_Clk        (i_Clk),
      .i_Reset      (i_Reset),
      .i_Segment_A  (i_Segment_A),
      .i_Segment_B  (i_Segment_B),
      .i_Segment_C  (i_Segment_C),
      .i_Segment_D  (i_Segment_D),
      .i_Segment_E  (i_Segment_E),
      .i_Segment_F  (i_Segment_F),
      .i_Segment_G  (i_Segment_G),
      .o_Binary_Num (o_Binary_Num),
      .o_Valid      (o_Valid),
      .o_Error      (o_Error),
      .o_Blank      (o_Blank),
      .o_Dbg_State  (o_Dbg_State)
`ifdef SEG_ERROR_COUNT_EN
      ,
      .o_Error_Count(o_Error_Count)
`endif
   );

   // clock
   always #5 i_Clk = ~i_Clk;

   // checker
   task automatic check_val(input string tag, input int observed, input int expected);
      n_compared++;
      if (observed !== expected) begin
         n_mismatched++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drive pattern p (1 = lit) as active-low lines, then watch `hold` falling
   // edges. first_* is the 1-based edge index of the first event (0 = none).
   task automatic run_pattern(input logic [6:0] p, input int hold,
                              output int first_valid, output int n_valid,
                              output int first_error, output int n_error,
                              output int first_blank);
      {i_Segment_A, i_Segment_B, i_Segment_C, i_Segment_D,
       i_Segment_E, i_Segment_F, i_Segment_G} = ~p;
      first_valid = 0; n_valid = 0; first_error = 0; n_error = 0; first_blank = 0;
      for (int i = 1; i <= hold; i++) begin
         @(negedge i_Clk);
         if (o_Valid) begin
            n_valid++;
            if (first_valid == 0) first_valid = i;
         end
         if (o_Error) begin
            n_error++;
            if (first_error == 0) first_error = i;
         end
         if (o_Blank && first_blank == 0) first_blank = i;
         if (o_Valid && o_Error) n_both++;
      end
   endtask

   task automatic check_reset_values(input string tag);
      check_val({tag, "_num"},   int'(o_Binary_Num), 0);
      check_val({tag, "_valid"}, int'(o_Valid), 0);
      check_val({tag, "_error"}, int'(o_Error), 0);
      check_val({tag, "_blank"}, int'(o_Blank), 0);
      check_val({tag, "_state"}, int'(o_Dbg_State), int'(ST_IDLE));
`ifdef SEG_ERROR_COUNT_EN
      check_val({tag, "_errcnt"}, int'(o_Error_Count), 0);
`endif
   endtask

   initial begin
      int fv, nv, fe, ne, fb, total_valid;
      logic [6:0] digits [16];
      digits = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                 7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

      // reset with all lines high (blank)
      i_Reset = 1'b1;
      repeat (3) @(negedge i_Clk);
      check_reset_values("rst");
      i_Reset = 1'b0;

      // blank straight after reset: accepted through IDLE after 6 clocks
      run_pattern(7'h00, 10, fv, nv, fe, ne, fb);
      check_val("init_blank_at", fb, 6);
      check_val("init_blank_nvalid", nv, 0);
      check_val("init_blank_nerror", ne, 0);

      // steady 5B -> single valid 6 clocks later, digit 5
      run_pattern(7'h5B, 16, fv, nv, fe, ne, fb);
      check_val("d5_valid_at", fv, 6);
      check_val("d5_nvalid", nv, 1);
      check_val("d5_num", int'(o_Binary_Num), 5);
      check_val("d5_blank", int'(o_Blank), 0);
      check_val("d5_state", int'(o_Dbg_State), int'(ST_LOCKED));

      // toggle 30/6D every 3 clocks -> never valid
      total_valid = 0;
      for (int k = 0; k < 6; k++) begin
         run_pattern((k % 2 == 0) ? 7'h30 : 7'h6D, 3, fv, nv, fe, ne, fb);
         total_valid += nv;
      end
      check_val("toggle_nvalid", total_valid, 0);
      check_val("toggle_num_held", int'(o_Binary_Num), 5);
      // hold 6D (already driven 3 clocks) -> valid on the 6th clock overall
      run_pattern(7'h6D, 10, fv, nv, fe, ne, fb);
      check_val("d2_valid_at", fv, 3);
      check_val("d2_nvalid", nv, 1);
      check_val("d2_num", int'(o_Binary_Num), 2);

      // illegal 01 -> single error pulse, digit held
      run_pattern(7'h01, 12, fv, nv, fe, ne, fb);
      check_val("ill_error_at", fe, 6);
      check_val("ill_nerror", ne, 1);
      check_val("ill_nvalid", nv, 0);
      check_val("ill_num", int'(o_Binary_Num), 2);
      check_val("ill_blank", int'(o_Blank), 0);
`ifdef SEG_ERROR_COUNT_EN
      check_val("ill_errcnt", int'(o_Error_Count), 1);
`endif

      // digit F, then blank -> blank after 6 clocks, F held
      run_pattern(7'h47, 10, fv, nv, fe, ne, fb);
      check_val("dF_valid_at", fv, 6);
      check_val("dF_num", int'(o_Binary_Num), 15);
      run_pattern(7'h00, 10, fv, nv, fe, ne, fb);
      check_val("blank_at", fb, 6);
      check_val("blank_nvalid", nv, 0);
      check_val("blank_nerror", ne, 0);
      check_val("blank_num", int'(o_Binary_Num), 15);

      // reset 2 clocks into SETTLE on 7F -> pending pattern discarded
      run_pattern(7'h7F, 3, fv, nv, fe, ne, fb);
      check_val("pre_rst_nvalid", nv, 0);
      i_Reset = 1'b1;
      repeat (2) @(negedge i_Clk);
      check_reset_values("mid_rst");
      i_Reset = 1'b0;
      run_pattern(7'h7F, 10, fv, nv, fe, ne, fb);
      check_val("post_rst_valid_at", fv, 6);
      check_val("post_rst_nvalid", nv, 1);
      check_val("post_rst_num", int'(o_Binary_Num), 8);

      // sweep all sixteen digits, 10 clocks each
      total_valid = 0;
      for (int d = 0; d < 16; d++) begin
         run_pattern(digits[d], 10, fv, nv, fe, ne, fb);
         total_valid += nv;
         check_val($sformatf("sweep%0d_valid_at", d), fv, 6);
         check_val($sformatf("sweep%0d_num", d), int'(o_Binary_Num), d);
      end
      check_val("sweep_total_valid", total_valid, 16);

      // brief glitch to E then back to F -> F re-accepted with a new pulse
      run_pattern(7'h4F, 2, fv, nv, fe, ne, fb);
      check_val("glitch_nvalid", nv, 0);
      run_pattern(7'h47, 10, fv, nv, fe, ne, fb);
      check_val("reacq_valid_at", fv, 6);
      check_val("reacq_nvalid", nv, 1);
      check_val("reacq_num", int'(o_Binary_Num), 15);

      check_val("valid_error_overlap", n_both, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/seven_segment_to_binary.md
SEVEN_SEGMENT_TO_BINARY -- requirements
Module: seven_segment_to_binary

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, is the number of consecutive identical registered samples required before a pattern is accepted; legal range 1..255.
REQ-002 i_Clk  input  1  single system clock; all logic is on its rising edge.
REQ-003 i_Reset  input  1  reset; synchronous, active-high.
REQ-004 i_Segment_A..i_Segment_G  input  1 each  active-low segment lines, A..G.
REQ-005 o_Binary_Num  output  4  last legally decoded hex digit.
REQ-006 o_Valid  output  1  one-cycle pulse when a legal digit is accepted.
REQ-007 o_Error  output  1  one-cycle pulse when a stable non-blank pattern matches no digit.
REQ-008 o_Blank  output  1  level; high while the accepted pattern is all segments off.

Function
REQ-009 Segment inputs SHALL be inverted and registered each cycle into a 7-bit pattern {A,B,C,D,E,F,G}, with A as MSB.
REQ-010 Legal patterns SHALL be 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B, A=77, b=1F, C=4E, d=3D, E=4F, F=47 (hex); pattern 00 is blank; all others are illegal.
REQ-011 The FSM SHALL have states IDLE, SETTLE and LOCKED.
REQ-012 A registered pattern that differs from the previous registered pattern SHALL clear the stability counter and force SETTLE, from any state.
REQ-013 In SETTLE, an unchanged pattern SHALL increment the counter; on reaching STABLE_CYCLES-1 the pattern is accepted and the FSM enters LOCKED.
REQ-014 Latency from a new pattern appearing on the inputs to o_Valid, o_Error or o_Blank updating SHALL be exactly STABLE_CYCLES+2 clocks.
REQ-015 On acceptance of a legal pattern: o_Binary_Num is loaded, o_Valid pulses for one cycle, and o_Blank clears.
REQ-016 On acceptance of an illegal pattern: o_Error pulses for one cycle, o_Binary_Num holds, and o_Blank clears.
REQ-017 On acceptance of blank: o_Blank goes high, with no o_Valid and no o_Error; o_Binary_Num holds.
REQ-018 In LOCKED, a steady pattern SHALL produce no further pulses; re-acceptance of the same pattern after a change and return SHALL pulse again.
REQ-019 The stability counter SHALL saturate and never wrap.
REQ-020 o_Valid and o_Error SHALL never be high in the same cycle.

Reset
REQ-021 i_Reset SHALL set the FSM to IDLE and clear the counter, the pattern register and the previous-pattern register.
REQ-022 Reset values SHALL be o_Binary_Num=0, o_Valid=0, o_Error=0, o_Blank=0.
REQ-023 Reset asserted mid-SETTLE SHALL discard the pending pattern; no pulse is produced for it.
REQ-024 Leaving IDLE SHALL follow the same SETTLE rules as any change, with the first registered sample treated as a change.

Configuration
REQ-025 With macro SEG_ERROR_COUNT_EN defined, an output o_Error_Count [7:0] SHALL be present; it increments on each o_Error pulse, saturates at 255, and resets to 0.
REQ-026 Without SEG_ERROR_COUNT_EN, the port and its logic SHALL be absent, with all other behaviour identical.

Structure
REQ-027 Package seg7_pkg SHALL hold the 16 digit pattern constants, the blank constant and the FSM state typedef, shared with the existing encoder.
REQ-028 Sub-module segment_pattern_lookup SHALL provide the combinational 7-bit-to-{hit,digit} match; all sequential logic stays in the top module.

Verification
REQ-029 Drive the active-low form of 5B steady with STABLE_CYCLES=4 -> o_Valid pulses exactly 6 clocks later, o_Binary_Num=5, a single pulse only.
REQ-030 Toggle the pattern between 30 and 6D every 3 clocks with STABLE_CYCLES=4 -> no o_Valid ever; then hold 6D -> one o_Valid with o_Binary_Num=2.
REQ-031 Drive illegal pattern 01 steady -> a single o_Error pulse, o_Binary_Num unchanged; with SEG_ERROR_COUNT_EN, o_Error_Count=1.
REQ-032 Drive all inputs high (blank) after digit F -> o_Blank=1 after 6 clocks, no o_Valid and no o_Error, o_Binary_Num stays F.
REQ-033 Assert i_Reset 2 clocks into SETTLE on 7F -> outputs return to reset values, and no pulse occurs until 6 clocks after reset release.
REQ-034 Sweep all 16 legal patterns, each held 10 clocks -> 16 o_Valid pulses with o_Binary_Num 0..F in order.
